// File: rtl/bus_arbiter_rx.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rx
//
// Bus master for a shared tri-state bus that two sources (A, B) drive through
// complementary bufif1/bufif0 drivers. It arbitrates the two requests
// round-robin, steers the drivers with sel_o, and holds sel_o stable for
// SETTLE_CYC cycles so the bus can settle. It then captures the bus word,
// pulses an ack back to the winning source, and offers the word downstream on
// a valid/ready handshake.
//
// State table
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | no transfer in flight; arbitrate incoming requests
//   ST_SETTLE | sel_o driven to the granted source, bus settling
//   ST_HOLD   | word captured, out_valid_o high until downstream accepts
//
// Parameters
//   WIDTH       bus / data width in bits
//   SETTLE_CYC  cycles sel_o is held before the bus is sampled (1..15)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_a_i      source A transfer request, held until ack_a_o
//   req_b_i      source B transfer request, held until ack_b_o
//   sel_o        bus select: 1 = A drives the bus, 0 = B drives the bus
//   bus_in_i     shared bus value
//   ack_a_o      one-cycle pulse: A's word has been captured
//   ack_b_o      one-cycle pulse: B's word has been captured
//   out_data_o   captured word
//   out_src_o    source of out_data_o: 1 = A, 0 = B
//   out_valid_o  out_data_o / out_src_o valid
//   out_ready_i  downstream accepts when out_valid_o & out_ready_i
//   busy_o       high whenever the FSM is not in ST_IDLE
// -----------------------------------------------------------------------------
module bus_arbiter_rx #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_a_i,
   input  logic             req_b_i,
   output logic             sel_o,
   input  logic [WIDTH-1:0] bus_in_i,
   output logic             ack_a_o,
   output logic             ack_b_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_src_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   // Counter reload: the capture happens on the edge where the count is zero,
   // so loading SETTLE_CYC-1 gives exactly SETTLE_CYC cycles of stable sel.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             last_grant_q, last_grant_d;   // 1 = A, 0 = B
   logic [3:0]       cnt_q, cnt_d;
   logic             ack_a_q, ack_a_d;
   logic             ack_b_q, ack_b_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic             any_req;
   logic             grant_a;
   logic             granted_req;
   logic             settle_done;

   // A wins when it is the only requester, or on contention when B had the
   // previous grant. sel_q only moves on a grant, so it doubles as the record
   // of which source owns the transfer in flight.
   assign any_req     = req_a_i | req_b_i;
   assign grant_a     = req_a_i & (~req_b_i | ~last_grant_q);
   assign granted_req = sel_q ? req_a_i : req_b_i;
   assign settle_done = (cnt_q == 4'd0);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b1;
         last_grant_q <= 1'b0;
         cnt_q        <= 4'd0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!granted_req) begin
               state_d = ST_IDLE;
            end else if (settle_done) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // out_valid_q is always high here, so ready alone completes it.
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      ack_a_d      = 1'b0;
      ack_b_d      = 1'b0;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      out_valid_d  = out_valid_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               sel_d = grant_a;
               cnt_d = CNT_INIT;
            end
         end
         ST_SETTLE: begin
            // An aborted transfer leaves last_grant alone so the dropped
            // source does not lose its round-robin turn.
            if (granted_req) begin
               if (!settle_done) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  out_data_d   = bus_in_i;
                  out_src_d    = sel_q;
                  out_valid_d  = 1'b1;
                  ack_a_d      = sel_q;
                  ack_b_d      = ~sel_q;
                  last_grant_d = sel_q;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign sel_o       = sel_q;
   assign ack_a_o     = ack_a_q;
   assign ack_b_o     = ack_b_q;
   assign out_data_o  = out_data_q;
   assign out_src_o   = out_src_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rx.sv
module tb_bus_arbiter_rx;

   logic       clk;
   logic       rst;

   // DUT with SETTLE_CYC = 1
   logic       req_a, req_b, sel, ack_a, ack_b, out_src, out_valid, out_ready, busy;
   logic [7:0] word_a, word_b, bus, out_data;

   // DUT with SETTLE_CYC = 3
   logic       req_a3, req_b3, sel3, ack_a3, ack_b3, out_src3, out_valid3, out_ready3, busy3;
   logic [7:0] word_a3, word_b3, bus3, out_data3;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] scb_q[$];   // {src, data}
   logic       found;

   // Behavioural stand-in for the complementary tri-state drivers.
   assign bus  = sel  ? word_a  : word_b;
   assign bus3 = sel3 ? word_a3 : word_b3;

   bus_arbiter_rx #(.WIDTH(8), .SETTLE_CYC(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_a_i(req_a), .req_b_i(req_b), .sel_o(sel),
      .bus_in_i(bus), .ack_a_o(ack_a), .ack_b_o(ack_b), .out_data_o(out_data),
      .out_src_o(out_src), .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
   );

   bus_arbiter_rx #(.WIDTH(8), .SETTLE_CYC(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .req_a_i(req_a3), .req_b_i(req_b3), .sel_o(sel3),
      .bus_in_i(bus3), .ack_a_o(ack_a3), .ack_b_o(ack_b3), .out_data_o(out_data3),
      .out_src_o(out_src3), .out_valid_o(out_valid3), .out_ready_i(out_ready3), .busy_o(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until dut1 shows an ack, bounded; leaves found set accordingly.
   task automatic wait_ack1(input string tag);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if (ack_a || ack_b) found = 1'b1;
      end
      check(tag, {31'd0, found}, 32'd1);
   endtask

   // Scoreboard: every accepted word of dut1 must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (scb_q.size() == 0) begin
            check("scb_unexpected_word", 32'(scb_q.size()), 32'd1);
         end else begin
            logic [8:0] e;
            e = scb_q.pop_front();
            check("scb_data", {24'd0, out_data}, {24'd0, e[7:0]});
            check("scb_src",  {31'd0, out_src},  {31'd0, e[8]});
         end
      end
   end

   initial begin
      rst = 1'b1; req_a = 0; req_b = 0; out_ready = 0; word_a = 0; word_b = 0;
      req_a3 = 0; req_b3 = 0; out_ready3 = 1; word_a3 = 0; word_b3 = 0;

      // 1: reset state
      tick(); tick();
      check("rst_sel",   {31'd0, sel},       32'd1);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ack_a", {31'd0, ack_a},     32'd0);
      check("rst_ack_b", {31'd0, ack_b},     32'd0);
      check("rst_data",  {24'd0, out_data},  32'h00);
      check("rst_src",   {31'd0, out_src},   32'd0);
      check("rst_busy",  {31'd0, busy},      32'd0);
      check("rst_busy3", {31'd0, busy3},     32'd0);
      rst = 1'b0;
      tick();

      // 2: single A transfer, SETTLE_CYC=1
      word_a = 8'hA5; word_b = 8'h5A; out_ready = 1;
      req_a = 1; scb_q.push_back({1'b1, 8'hA5});
      tick();
      check("s2_sel_t1",   {31'd0, sel},   32'd1);
      check("s2_busy_t1",  {31'd0, busy},  32'd1);
      check("s2_ack_a_t1", {31'd0, ack_a}, 32'd0);
      tick();
      check("s2_ack_a_t2", {31'd0, ack_a},     32'd1);
      check("s2_valid_t2", {31'd0, out_valid}, 32'd1);
      check("s2_ack_b_t2", {31'd0, ack_b},     32'd0);
      check("s2_data_t2",  {24'd0, out_data},  32'hA5);
      req_a = 0;
      tick();
      check("s2_ack_a_t3", {31'd0, ack_a},     32'd0);
      check("s2_valid_t3", {31'd0, out_valid}, 32'd0);
      check("s2_busy_t3",  {31'd0, busy},      32'd0);
      check("s2_ack_b_t3", {31'd0, ack_b},     32'd0);

      // 3: continuous contention after a fresh reset -> A, B, A, B
      rst = 1; tick(); rst = 0;
      word_a = 8'h11; word_b = 8'h22;
      for (int i = 0; i < 4; i++) scb_q.push_back((i % 2 == 0) ? {1'b1, 8'h11} : {1'b0, 8'h22});
      req_a = 1; req_b = 1;
      for (int i = 0; i < 4; i++) begin
         logic exp_a;
         exp_a = (i % 2 == 0);
         wait_ack1($sformatf("s3_ack_seen_%0d", i));
         check($sformatf("s3_sel_%0d", i),   {31'd0, sel},   {31'd0, exp_a});
         check($sformatf("s3_ack_a_%0d", i), {31'd0, ack_a}, {31'd0, exp_a});
         check($sformatf("s3_ack_b_%0d", i), {31'd0, ack_b}, {31'd0, ~exp_a});
         if (i == 3) begin
            req_a = 0; req_b = 0;
         end else if (exp_a) begin
            req_a = 0; tick(); req_a = 1;
         end else begin
            req_b = 0; tick(); req_b = 1;
         end
      end
      tick(); tick();
      check("s3_idle_busy", {31'd0, busy}, 32'd0);

      // 4: B captured while downstream stalls, A waiting
      word_b = 8'h3C; word_a = 8'h5A; out_ready = 0;
      req_b = 1; scb_q.push_back({1'b0, 8'h3C});
      wait_ack1("s4_ack_seen");
      check("s4_ack_b", {31'd0, ack_b},    32'd1);
      check("s4_data",  {24'd0, out_data}, 32'h3C);
      req_b = 0; req_a = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("s4_valid_%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("s4_data_%0d", i),  {24'd0, out_data},  32'h3C);
         check($sformatf("s4_sel_%0d", i),   {31'd0, sel},       32'd0);
         check($sformatf("s4_ack_a_%0d", i), {31'd0, ack_a},     32'd0);
      end
      out_ready = 1; scb_q.push_back({1'b1, 8'h5A});
      wait_ack1("s4_a_ack_seen");
      check("s4_a_ack_a", {31'd0, ack_a},    32'd1);
      check("s4_a_sel",   {31'd0, sel},      32'd1);
      check("s4_a_data",  {24'd0, out_data}, 32'h5A);
      req_a = 0;
      tick(); tick();

      // 5: SETTLE_CYC=3 - full A transfer, then aborted B, then contention
      word_a3 = 8'hC3; word_b3 = 8'h4B;
      req_a3 = 1;
      tick();
      check("s5_sel_grant", {31'd0, sel3}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("s5_ack_early_%0d", i), {31'd0, ack_a3}, 32'd0);
      end
      tick();
      check("s5_ack_a3",  {31'd0, ack_a3},     32'd1);
      check("s5_valid3",  {31'd0, out_valid3}, 32'd1);
      check("s5_data3",   {24'd0, out_data3},  32'hC3);
      req_a3 = 0;
      tick();
      req_b3 = 1;
      tick();
      check("s5_abort_sel",  {31'd0, sel3},  32'd0);
      check("s5_abort_busy", {31'd0, busy3}, 32'd1);
      tick();
      req_b3 = 0;
      tick();
      check("s5_abort_busy0", {31'd0, busy3},      32'd0);
      check("s5_abort_ack_b", {31'd0, ack_b3},     32'd0);
      check("s5_abort_valid", {31'd0, out_valid3}, 32'd0);
      req_a3 = 1; req_b3 = 1;
      tick();
      check("s5_rr_after_abort", {31'd0, sel3}, 32'd0);
      req_a3 = 0; req_b3 = 0;
      tick(); tick();

      // 6: reset in HOLD drops the word, then a fresh A transfer
      word_b = 8'h77; out_ready = 0;
      req_b = 1;
      wait_ack1("s6_ack_seen");
      req_b = 0;
      tick();
      check("s6_hold_valid", {31'd0, out_valid}, 32'd1);
      rst = 1;
      tick();
      rst = 0;
      check("s6_rst_valid", {31'd0, out_valid}, 32'd0);
      check("s6_rst_sel",   {31'd0, sel},       32'd1);
      check("s6_rst_busy",  {31'd0, busy},      32'd0);
      check("s6_rst_data",  {24'd0, out_data},  32'h00);
      out_ready = 1; word_a = 8'hA5;
      req_a = 1; scb_q.push_back({1'b1, 8'hA5});
      tick();
      check("s6_sel_t1", {31'd0, sel},   32'd1);
      tick();
      check("s6_ack_a_t2", {31'd0, ack_a},    32'd1);
      check("s6_data_t2",  {24'd0, out_data}, 32'hA5);
      req_a = 0;
      tick(); tick();

      check("scb_drained", 32'(scb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
